// File: rtl/starfield_pkg.sv
// Shared types and constants for the starfield layer sequencer.
package starfield_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_STAGGER  = 3'd1,
        ST_FADE_IN  = 3'd2,
        ST_RUN      = 3'd3,
        ST_FADE_OUT = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_START    = 2'd1,
        OP_STOP     = 2'd2,
        OP_SET_RATE = 2'd3
    } seq_op_t;

    localparam logic [3:0] GAIN_MAX = 4'd15;

endpackage

// File: rtl/starfield_seq_frame_step.sv
// Frame divider for gain fades: pulses step on every (rate+1)-th frame.
// Only present when STARFIELD_SEQ_FADE_EN is defined.
`ifdef STARFIELD_SEQ_FADE_EN
module frame_step #(
    parameter int RATEW = 4
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             frame,
    input  logic             clr,
    input  logic [RATEW-1:0] rate,
    output logic             step
);

    logic [RATEW-1:0] fcnt;

    // >= rather than == so a rate lowered below fcnt still steps next frame.
    assign step = frame && !clr && (fcnt >= rate);

    always_ff @(posedge clk_pix) begin
        if (rst || clr) begin
            fcnt <= '0;
        end else if (frame) begin
            fcnt <= step ? '0 : fcnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/starfield_seq.sv
// Frame-synchronous sequencer: staggers layer resets and fades a shared gain.
// STARFIELD_SEQ_FADE_EN enables stepped fades; otherwise gain jumps 0<->15.
module starfield_seq
    import starfield_pkg::*;
#(
    parameter int LAYERS = 3,
    parameter int RATEW  = 4
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              frame,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [RATEW-1:0]  cmd_arg,
    output logic [LAYERS-1:0] layer_rst,
    output logic [LAYERS-1:0] layer_en,
    output logic [3:0]        gain,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready;
    // START/STOP then occupy the single pending slot until the next frame.
    seq_state_t state;
    seq_op_t    pend_op;
    seq_op_t    op_in;
    logic       pend_v;
    logic [2:0] lidx;
    logic       accept;
    logic       fading;
    logic       op_hit;
    logic       step;
    logic [3:0] gain_step;
    logic [3:0] gain_nxt;

    assign op_in     = seq_op_t'(cmd_op);
    assign cmd_ready = !pend_v;
    assign accept    = cmd_valid && cmd_ready;
    assign layer_en  = ~layer_rst;
    assign dbg_state = state;

    always_comb begin
        fading = (state == ST_FADE_IN) || (state == ST_FADE_OUT);
        op_hit = frame && pend_v &&
                 (((pend_op == OP_START) && ((state == ST_OFF) || (state == ST_FADE_OUT))) ||
                  ((pend_op == OP_STOP)  && ((state == ST_STAGGER) || (state == ST_FADE_IN) ||
                                             (state == ST_RUN))));
    end

`ifdef STARFIELD_SEQ_FADE_EN
    logic [RATEW-1:0] rate;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            rate <= '0;
        end else if (accept && (op_in == OP_SET_RATE)) begin
            rate <= cmd_arg;
        end
    end

    // Counter is held clear outside fades and on every fade-direction change.
    frame_step #(.RATEW(RATEW)) u_frame_step (
        .clk_pix (clk_pix),
        .rst     (rst),
        .frame   (frame),
        .clr     (!fading || op_hit),
        .rate    (rate),
        .step    (step)
    );

    always_comb begin
        if (state == ST_FADE_IN) begin
            gain_step = (gain == GAIN_MAX) ? gain : gain + 4'd1;
        end else begin
            gain_step = (gain == 4'd0) ? gain : gain - 4'd1;
        end
    end
`else
    logic unused_arg;

    assign unused_arg = ^cmd_arg;
    assign step       = frame && fading && !op_hit;
    assign gain_step  = (state == ST_FADE_IN) ? GAIN_MAX : 4'd0;
`endif

    assign gain_nxt = step ? gain_step : gain;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state     <= ST_OFF;
            layer_rst <= '1;
            gain      <= '0;
            busy      <= 1'b0;
            pend_v    <= 1'b0;
            pend_op   <= OP_NOP;
            lidx      <= '0;
        end else begin
            if (frame && pend_v) begin
                pend_v <= 1'b0;
            end else if (accept && ((op_in == OP_START) || (op_in == OP_STOP))) begin
                pend_v  <= 1'b1;
                pend_op <= op_in;
            end

            if (frame) begin
                if (op_hit) begin
                    case (state)
                        ST_OFF: begin
                            state        <= ST_STAGGER;
                            layer_rst[0] <= 1'b0;
                            lidx         <= 3'd1;
                            busy         <= 1'b1;
                        end
                        ST_STAGGER: begin
                            state     <= ST_OFF;
                            layer_rst <= '1;
                            busy      <= 1'b0;
                        end
                        ST_FADE_OUT: state <= ST_FADE_IN;
                        default: begin
                            state <= ST_FADE_OUT;
                            busy  <= 1'b1;
                        end
                    endcase
                end else begin
                    case (state)
                        ST_STAGGER: begin
                            for (int i = 0; i < LAYERS; i++) begin
                                if (int'(lidx) == i) layer_rst[i] <= 1'b0;
                            end
                            lidx <= lidx + 3'd1;
                            if (int'(lidx) >= LAYERS - 1) state <= ST_FADE_IN;
                        end
                        // Terminal checks look at the post-step gain of this frame.
                        ST_FADE_IN: begin
                            gain <= gain_nxt;
                            if (gain_nxt == GAIN_MAX) begin
                                state <= ST_RUN;
                                busy  <= 1'b0;
                            end
                        end
                        ST_FADE_OUT: begin
                            gain <= gain_nxt;
                            if (gain_nxt == 4'd0) begin
                                state     <= ST_OFF;
                                layer_rst <= '1;
                                busy      <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_starfield_seq.sv
// Bench for starfield_seq: directed sequences plus random commands/frames,
// checked every cycle against a frame-level behavioural model.
module tb_starfield_seq;
    import starfield_pkg::*;

    localparam int LAYERS = 3;
    localparam int RATEW  = 4;
`ifdef STARFIELD_SEQ_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic              clk_pix = 1'b0;
    logic              rst;
    logic              frame;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [RATEW-1:0]  cmd_arg;
    logic              cmd_ready;
    logic [LAYERS-1:0] layer_rst;
    logic [LAYERS-1:0] layer_en;
    logic [3:0]        gain;
    logic              busy;
    logic [2:0]        dbg_state;

    int total = 0;
    int bad   = 0;

    // Model: phase, count of released layers, gain, fade divider, pending slot.
    seq_state_t m_ph;
    int         m_rel;
    int         m_gain;
    int         m_rate;
    int         m_fcnt;
    bit         m_pv;
    logic [1:0] m_pop;

    starfield_seq #(.LAYERS(LAYERS), .RATEW(RATEW)) dut (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .frame     (frame),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .layer_rst (layer_rst),
        .layer_en  (layer_en),
        .gain      (gain),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [LAYERS-1:0] exp_rst;
        logic [LAYERS-1:0] exp_en;
        logic [31:0]       all_mask;
        all_mask = (32'd1 << LAYERS) - 1;
        exp_rst  = LAYERS'(all_mask & ~((32'd1 << m_rel) - 1));
        exp_en   = ~exp_rst;
        check("layer_rst", 32'(layer_rst), 32'(exp_rst));
        check("layer_en",  32'(layer_en),  32'(exp_en));
        check("gain",      32'(gain),      m_gain);
        check("busy",      32'(busy),      32'((m_ph != ST_OFF) && (m_ph != ST_RUN)));
        check("cmd_ready", 32'(cmd_ready), 32'(!m_pv));
        check("state",     32'(dbg_state), 32'(m_ph));
    endtask

    task automatic model_reset();
        m_ph   = ST_OFF;
        m_rel  = 0;
        m_gain = 0;
        m_rate = 0;
        m_fcnt = 0;
        m_pv   = 1'b0;
        m_pop  = 2'd0;
    endtask

    task automatic model_frame(input bit pv, input logic [1:0] pop);
        bit eff;
        int dir;
        eff = pv && (((pop == 2'd1) && ((m_ph == ST_OFF) || (m_ph == ST_FADE_OUT))) ||
                     ((pop == 2'd2) && ((m_ph == ST_STAGGER) || (m_ph == ST_FADE_IN) ||
                                        (m_ph == ST_RUN))));
        if (eff) begin
            case (m_ph)
                ST_OFF:      begin m_ph = ST_STAGGER; m_rel = 1; end
                ST_STAGGER:  begin m_ph = ST_OFF; m_rel = 0; end
                ST_FADE_OUT: begin m_ph = ST_FADE_IN; m_fcnt = 0; end
                default:     begin m_ph = ST_FADE_OUT; m_fcnt = 0; end
            endcase
        end else if (m_ph == ST_STAGGER) begin
            m_rel++;
            if (m_rel >= LAYERS) begin
                m_rel  = LAYERS;
                m_ph   = ST_FADE_IN;
                m_fcnt = 0;
            end
        end else if ((m_ph == ST_FADE_IN) || (m_ph == ST_FADE_OUT)) begin
            dir = (m_ph == ST_FADE_IN) ? 1 : -1;
            if (!FADE) begin
                m_gain = (dir > 0) ? 15 : 0;
            end else if (m_fcnt >= m_rate) begin
                m_gain = m_gain + dir;
                if (m_gain > 15) m_gain = 15;
                if (m_gain < 0)  m_gain = 0;
                m_fcnt = 0;
            end else begin
                m_fcnt++;
            end
            if ((dir > 0) && (m_gain == 15)) begin
                m_ph = ST_RUN;
            end else if ((dir < 0) && (m_gain == 0)) begin
                m_ph  = ST_OFF;
                m_rel = 0;
            end
        end
    endtask

    task automatic model_edge(input bit f, input bit v, input logic [1:0] op, input logic [3:0] arg);
        bit         pv0;
        logic [1:0] pop0;
        bit         acc;
        pv0  = m_pv;
        pop0 = m_pop;
        acc  = v && !m_pv;
        if (f) model_frame(pv0, pop0);
        if (f && pv0) begin
            m_pv = 1'b0;
        end else if (acc && ((op == 2'd1) || (op == 2'd2))) begin
            m_pv  = 1'b1;
            m_pop = op;
        end
        if (acc && (op == 2'd3) && FADE) m_rate = int'(arg);
    endtask

    task automatic tick(input bit f, input bit v, input logic [1:0] op, input logic [3:0] arg);
        frame     = f;
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        model_edge(f, v, op, arg);
        @(posedge clk_pix);
        #1;
        frame     = 1'b0;
        cmd_valid = 1'b0;
        check_all();
    endtask

    task automatic do_rst();
        rst       = 1'b1;
        frame     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = '0;
        model_reset();
        @(posedge clk_pix);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    task automatic frames(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            for (int j = 1; j < gap; j++) tick(1'b0, 1'b0, 2'd0, 4'd0);
            tick(1'b1, 1'b0, 2'd0, 4'd0);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] arg);
        tick(1'b0, 1'b1, op, arg);
    endtask

    initial begin
        do_rst();

        // Power-up: stagger, fade in, run.
        cmd(2'd1, 4'd0);
        frames(20, 20);

        // Slow fade out with rate 2.
        cmd(2'd3, 4'd2);
        cmd(2'd2, 4'd0);
        frames(50, 8);

        // Reverse direction mid-fade in both directions.
        cmd(2'd3, 4'd0);
        cmd(2'd1, 4'd0);
        frames(10, 6);
        cmd(2'd2, 4'd0);
        frames(5, 6);
        cmd(2'd1, 4'd0);
        frames(20, 6);
        cmd(2'd2, 4'd0);
        frames(20, 6);

        // Command accepted in the frame cycle applies at the following frame.
        frames(1, 4);
        tick(1'b1, 1'b1, 2'd1, 4'd0);
        tick(1'b0, 1'b0, 2'd0, 4'd0);
        frames(3, 5);

        // Reset during stagger, then restart from layer 0.
        do_rst();
        cmd(2'd1, 4'd0);
        frames(2, 5);
        do_rst();
        cmd(2'd1, 4'd0);
        frames(22, 5);

        // NOP and redundant commands.
        cmd(2'd0, 4'd0);
        cmd(2'd1, 4'd0);
        frames(2, 4);

        // Random commands and frame pulses.
        for (int k = 0; k < 3000; k++) begin
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
